// File: rtl/sdram_cmd_pkg.sv
// Shared opcodes, response codes and FSM states
// for the SDRAM command bridge.
package sdram_cmd_pkg;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] RSP_ACK  = 8'hA5;
  localparam logic [7:0] RSP_ERR  = 8'hEE;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ROW_HI,
    S_ROW_LO,
    S_COL,
    S_DHI,
    S_DLO,
    S_ISSUE,
    S_WAIT,
    S_RSP0,
    S_RSP1
  } bridge_state_t;

  function automatic logic is_op(input logic [7:0] b);
    return (b == OP_WRITE) || (b == OP_READ);
  endfunction

endpackage

// File: rtl/sdram_cmd_watchdog.sv
// Completion watchdog: cleared on load, counts while
// enabled, flags expiry after LIMIT counted cycles.
module sdram_cmd_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic expire
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  assign expire = count && (cnt == W'(LIMIT - 1));

  // cycle counter, restarted on every load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (count && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sdram_cmd_bridge.sv
// Byte-serial command front end for sdram_controller.
// Optional WAIT timeout: SDRAM_CMD_BRIDGE_TIMEOUT_EN.
module sdram_cmd_bridge
  import sdram_cmd_pkg::*;
#(
  parameter int ROW_W          = 12,
  parameter int COL_W          = 8,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        rsp_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  input  logic              ctrl_ready,
  output logic [ROW_W-1:0]  ctrl_row,
  output logic [COL_W-1:0]  ctrl_col,
  output logic [DATA_W-1:0] ctrl_wdata,
  output logic              ctrl_wr_start,
  output logic              ctrl_rd_start,
  input  logic              ctrl_wr_done,
  input  logic              ctrl_rd_valid,
  input  logic [DATA_W-1:0] ctrl_rdata,
  output logic              busy
);

  bridge_state_t state, state_nx;

  logic       in_rdy_s;
  logic       wr_go;
  logic       rd_go;
  logic       accept;
  logic       done_hit;
  logic       wd_expire;
  logic       rsp_take;
  logic       is_wr;
  logic       rsp_two;
  logic [7:0] row_hi;
  logic [7:0] rsp_lo;
  logic [7:0] err_cnt;

  assign in_ready      = rst_n & in_rdy_s;
  assign accept        = in_valid & in_ready;
  assign busy          = (state != S_IDLE);
  assign done_hit      = is_wr ? ctrl_wr_done : ctrl_rd_valid;
  assign rsp_take      = rsp_valid & rsp_ready;
  assign ctrl_wr_start = rst_n & wr_go;
  assign ctrl_rd_start = rst_n & rd_go;

`ifdef SDRAM_CMD_BRIDGE_TIMEOUT_EN
  sdram_cmd_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wd (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (state == S_ISSUE),
    .count  (state == S_WAIT),
    .expire (wd_expire)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign wd_expire = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // next state, byte acceptance and start pulses
  always_comb begin
    state_nx = state;
    in_rdy_s = 1'b0;
    wr_go    = 1'b0;
    rd_go    = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_rdy_s = 1'b1;
        if (in_valid && is_op(in_data))
          state_nx = S_ROW_HI;
      end
      S_ROW_HI: begin
        in_rdy_s = 1'b1;
        if (in_valid) state_nx = S_ROW_LO;
      end
      S_ROW_LO: begin
        in_rdy_s = 1'b1;
        if (in_valid) state_nx = S_COL;
      end
      S_COL: begin
        in_rdy_s = 1'b1;
        if (in_valid)
          state_nx = is_wr ? S_DHI : S_ISSUE;
      end
      S_DHI: begin
        in_rdy_s = 1'b1;
        if (in_valid) state_nx = S_DLO;
      end
      S_DLO: begin
        in_rdy_s = 1'b1;
        if (in_valid) state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        if (ctrl_ready) begin
          wr_go    = is_wr;
          rd_go    = !is_wr;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (done_hit || wd_expire)
          state_nx = S_RSP0;
      end
      S_RSP0: begin
        if (rsp_take)
          state_nx = rsp_two ? S_RSP1 : S_IDLE;
      end
      S_RSP1: begin
        if (rsp_take) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // frame assembly, response registers, error count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_wr      <= 1'b0;
      row_hi     <= '0;
      ctrl_row   <= '0;
      ctrl_col   <= '0;
      ctrl_wdata <= '0;
      rsp_data   <= '0;
      rsp_valid  <= 1'b0;
      rsp_lo     <= '0;
      rsp_two    <= 1'b0;
      err_cnt    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_op(in_data))
              is_wr <= (in_data == OP_WRITE);
            else if (err_cnt != 8'hFF)
              err_cnt <= err_cnt + 8'd1;
          end
        end
        S_ROW_HI: if (accept) row_hi <= in_data;
        S_ROW_LO: begin
          if (accept)
            ctrl_row <= ROW_W'({row_hi, in_data});
        end
        S_COL: if (accept) ctrl_col <= COL_W'(in_data);
        S_DHI: if (accept) ctrl_wdata[15:8] <= in_data;
        S_DLO: if (accept) ctrl_wdata[7:0] <= in_data;
        S_WAIT: begin
          if (done_hit) begin
            rsp_valid <= 1'b1;
            rsp_data  <= is_wr ? RSP_ACK : ctrl_rdata[15:8];
            rsp_lo    <= ctrl_rdata[7:0];
            rsp_two   <= !is_wr;
          end else if (wd_expire) begin
            rsp_valid <= 1'b1;
            rsp_data  <= RSP_ERR;
            rsp_two   <= 1'b0;
          end
        end
        S_RSP0: begin
          if (rsp_take) begin
            if (rsp_two) rsp_data  <= rsp_lo;
            else         rsp_valid <= 1'b0;
          end
        end
        S_RSP1: if (rsp_take) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
